rv32i_exec_core: RTL and testbench

// - Single-cycle RV32I execute core: decoder, 32x32 register file and ALU merged into one block.
// - Caller supplies the fetched instruction and its PC each cycle.
// - Block reads operands, computes the result and writes back rd.
// - Returns the next PC to the fetch stage; no memory port (load/store/fence/system are illegal).

---
 rtl/rv32i_exec_core.sv | 197 +++++++++++++++++++
 tb/tb_rv32i_exec_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_exec_core.sv
// Single-cycle RV32I execute core: decode, 32x32 register file and ALU, with one-cycle registered results.
// Optional debug read port enabled by defining RV32I_DBG_READ_EN.
module rv32i_exec_core #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_insn,
    input  logic [31:0] i_pc,
`ifdef RV32I_DBG_READ_EN
    input  logic [4:0]  i_dbg_addr,
    output logic [31:0] o_dbg_data,
`endif
    output logic        o_valid,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_wb_data,
    output logic        o_wb_en,
    output logic        o_br_taken,
    output logic        o_illegal
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [31:0] next_pc;
        logic [31:0] wb_data;
        logic        wb_en;
        logic        br_taken;
        logic        illegal;
    } exec_res_t;

    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] pc_plus4;
    logic [31:0] wr_val;
    logic        wr;
    logic        bad;
    logic        take;
    exec_res_t   res;

    assign opcode = i_insn[6:0];
    assign rd     = i_insn[11:7];
    assign funct3 = i_insn[14:12];
    assign rs1    = i_insn[19:15];
    assign rs2    = i_insn[24:20];
    assign funct7 = i_insn[31:25];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{i_insn[31]}}, i_insn[31:20]};
    assign imm_b = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
    assign imm_u = {i_insn[31:12], 12'b0};
    assign imm_j = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
    assign pc_plus4 = i_pc + 32'd4;

    // alt selects SUB over ADD and SRA over SRL; ignored for the other funct3 values
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb begin
        res         = '0;
        res.next_pc = pc_plus4;
        wr          = 1'b0;
        wr_val      = 32'd0;
        bad         = 1'b0;
        take        = 1'b0;
        case (opcode)
            OP_REG: begin
                if (funct7 == 7'd0 ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    wr     = 1'b1;
                    wr_val = alu(funct3, funct7[5], rs1_val, rs2_val);
                end else begin
                    bad = 1'b1;
                end
            end
            OP_IMM: begin
                // only the shift forms constrain the upper immediate bits
                if ((funct3 == 3'b001 && funct7 != 7'd0) ||
                    (funct3 == 3'b101 && funct7 != 7'd0 && funct7 != F7_ALT)) begin
                    bad = 1'b1;
                end else begin
                    wr     = 1'b1;
                    wr_val = alu(funct3, (funct3 == 3'b101) && i_insn[30], rs1_val, imm_i);
                end
            end
            OP_LUI: begin
                wr     = 1'b1;
                wr_val = imm_u;
            end
            OP_AUIPC: begin
                wr     = 1'b1;
                wr_val = i_pc + imm_u;
            end
            OP_JAL: begin
                wr          = 1'b1;
                wr_val      = pc_plus4;
                take        = 1'b1;
                res.next_pc = i_pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    wr          = 1'b1;
                    wr_val      = pc_plus4;
                    take        = 1'b1;
                    res.next_pc = (rs1_val + imm_i) & ~32'd1;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  take = (rs1_val == rs2_val);
                    3'b001:  take = (rs1_val != rs2_val);
                    3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
                    3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  take = (rs1_val < rs2_val);
                    3'b111:  take = (rs1_val >= rs2_val);
                    default: bad = 1'b1;
                endcase
                if (take) res.next_pc = i_pc + imm_b;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            res.next_pc = pc_plus4;
            take        = 1'b0;
            wr          = 1'b0;
        end
        res.illegal  = bad;
        res.br_taken = take;
        res.wb_en    = wr && (rd != 5'd0);
        res.wb_data  = res.wb_en ? wr_val : 32'd0;
    end

    // writes land at the edge, so the next instruction's combinational read sees them
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            o_valid    <= 1'b0;
            o_next_pc  <= RESET_PC;
            o_wb_data  <= 32'd0;
            o_wb_en    <= 1'b0;
            o_br_taken <= 1'b0;
            o_illegal  <= 1'b0;
        end else if (i_valid) begin
            if (res.wb_en) regs[rd] <= res.wb_data;
            o_valid    <= 1'b1;
            o_next_pc  <= res.next_pc;
            o_wb_data  <= res.wb_data;
            o_wb_en    <= res.wb_en;
            o_br_taken <= res.br_taken;
            o_illegal  <= res.illegal;
        end else begin
            o_valid <= 1'b0;
        end
    end

`ifdef RV32I_DBG_READ_EN
    assign o_dbg_data = (i_dbg_addr == 5'd0) ? 32'd0 : regs[i_dbg_addr];
`endif

endmodule

// File: tb/tb_rv32i_exec_core.sv
// Directed table-driven bench for rv32i_exec_core plus hand-written reset/hold sequences.
module tb_rv32i_exec_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        o_valid;
    logic [31:0] o_next_pc;
    logic [31:0] o_wb_data;
    logic        o_wb_en;
    logic        o_br_taken;
    logic        o_illegal;
`ifdef RV32I_DBG_READ_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32i_exec_core dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_valid    (valid),
        .i_insn     (insn),
        .i_pc       (pc),
`ifdef RV32I_DBG_READ_EN
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data),
`endif
        .o_valid    (o_valid),
        .o_next_pc  (o_next_pc),
        .o_wb_data  (o_wb_data),
        .o_wb_en    (o_wb_en),
        .o_br_taken (o_br_taken),
        .o_illegal  (o_illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] nxt;
        logic [31:0] wbd;
        logic        wen;
        logic        br;
        logic        ill;
    } vec_t;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
            input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] rdx);
        return {f7, r2, r1, f3, rdx, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
            input logic [2:0] f3, input logic [4:0] rdx, input logic [6:0] op);
        return {imm, r1, f3, rdx, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
            input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rdx);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rdx, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rdx,
            input logic [6:0] op);
        return {imm, rdx, op};
    endfunction

    task automatic check(input string name, input logic ov, input logic [31:0] nxt,
            input logic [31:0] wbd, input logic wen, input logic br, input logic ill);
        n_tests++;
        if ({o_valid, o_next_pc, o_wb_data, o_wb_en, o_br_taken, o_illegal} !==
            {ov, nxt, wbd, wen, br, ill}) begin
            n_fail++;
            $display("FAIL %s: got v=%b next=%h wb=%h en=%b br=%b ill=%b, want v=%b next=%h wb=%h en=%b br=%b ill=%b",
                     name, o_valid, o_next_pc, o_wb_data, o_wb_en, o_br_taken, o_illegal,
                     ov, nxt, wbd, wen, br, ill);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] OPI = 7'b0010011;
    vec_t vt[35];

    initial begin
        vt[0]  = '{"addi_m1",   32'hFFF00093, 32'h8000_0000, 32'h8000_0004, 32'hFFFF_FFFF, 1, 0, 0};
        vt[1]  = '{"addi_dep",  enc_i(12'd1, 5'd1, 3'b000, 5'd2, OPI), 32'h8000_0004, 32'h8000_0008, 32'h0, 1, 0, 0};
        vt[2]  = '{"addi_x2",   enc_i(12'd1, 5'd0, 3'b000, 5'd2, OPI), 32'h8000_0008, 32'h8000_000C, 32'h1, 1, 0, 0};
        vt[3]  = '{"slt",       enc_r(7'd0, 5'd2, 5'd1, 3'b010, 5'd3), 32'h8000_000C, 32'h8000_0010, 32'h1, 1, 0, 0};
        vt[4]  = '{"sltu",      enc_r(7'd0, 5'd2, 5'd1, 3'b011, 5'd3), 32'h8000_0100, 32'h8000_0104, 32'h0, 1, 0, 0};
        vt[5]  = '{"sra",       enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd4), 32'h8000_0104, 32'h8000_0108, 32'hFFFF_FFFF, 1, 0, 0};
        vt[6]  = '{"srl",       enc_r(7'd0, 5'd2, 5'd1, 3'b101, 5'd4), 32'h8000_0108, 32'h8000_010C, 32'h7FFF_FFFF, 1, 0, 0};
        vt[7]  = '{"sub",       enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd5), 32'h8000_010C, 32'h8000_0110, 32'h2, 1, 0, 0};
        vt[8]  = '{"sll",       enc_r(7'd0, 5'd2, 5'd2, 3'b001, 5'd10), 32'h8000_0110, 32'h8000_0114, 32'h2, 1, 0, 0};
        vt[9]  = '{"xor",       enc_r(7'd0, 5'd2, 5'd1, 3'b100, 5'd10), 32'h8000_0114, 32'h8000_0118, 32'hFFFF_FFFE, 1, 0, 0};
        vt[10] = '{"beq_taken", enc_b(13'd8, 5'd0, 5'd0, 3'b000), 32'h8000_0010, 32'h8000_0018, 32'h0, 0, 1, 0};
        vt[11] = '{"bne_not",   enc_b(13'd8, 5'd0, 5'd0, 3'b001), 32'h8000_0010, 32'h8000_0014, 32'h0, 0, 0, 0};
        vt[12] = '{"jal",       enc_j(21'd16, 5'd1), 32'h8000_0020, 32'h8000_0030, 32'h8000_0024, 1, 1, 0};
        vt[13] = '{"jalr_odd",  enc_i(12'd3, 5'd1, 3'b000, 5'd0, 7'b1100111), 32'h8000_0030, 32'h8000_0026, 32'h0, 0, 1, 0};
        vt[14] = '{"ill_load0", 32'h0000_0003, 32'h8000_0040, 32'h8000_0044, 32'h0, 0, 0, 1};
        vt[15] = '{"ill_lw_x1", enc_i(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011), 32'h8000_0044, 32'h8000_0048, 32'h0, 0, 0, 1};
        vt[16] = '{"addi_x0",   enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPI), 32'h8000_0048, 32'h8000_004C, 32'h0, 0, 0, 0};
        vt[17] = '{"read_x0",   enc_i(12'd0, 5'd0, 3'b000, 5'd6, OPI), 32'h8000_004C, 32'h8000_0050, 32'h0, 1, 0, 0};
        vt[18] = '{"read_x1",   enc_i(12'd0, 5'd1, 3'b000, 5'd6, OPI), 32'h8000_0050, 32'h8000_0054, 32'h8000_0024, 1, 0, 0};
        vt[19] = '{"lui",       enc_u(20'h12345, 5'd7, 7'b0110111), 32'h8000_0054, 32'h8000_0058, 32'h1234_5000, 1, 0, 0};
        vt[20] = '{"auipc",     enc_u(20'h00001, 5'd7, 7'b0010111), 32'h8000_0100, 32'h8000_0104, 32'h8000_1100, 1, 0, 0};
        vt[21] = '{"jalr_rd_rs1", enc_i(12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111), 32'h8000_0200, 32'h8000_0024, 32'h8000_0204, 1, 1, 0};
        vt[22] = '{"ill_op_f7", enc_r(7'h20, 5'd2, 5'd1, 3'b001, 5'd8), 32'h8000_0210, 32'h8000_0214, 32'h0, 0, 0, 1};
        vt[23] = '{"ill_slli",  enc_i(12'h024, 5'd1, 3'b001, 5'd8, OPI), 32'h8000_0214, 32'h8000_0218, 32'h0, 0, 0, 1};
        vt[24] = '{"srai",      enc_i(12'h404, 5'd1, 3'b101, 5'd8, OPI), 32'h8000_0218, 32'h8000_021C, 32'hF800_0020, 1, 0, 0};
        vt[25] = '{"blt_back",  enc_b(-13'sd4, 5'd2, 5'd1, 3'b100), 32'h8000_0300, 32'h8000_02FC, 32'h0, 0, 1, 0};
        vt[26] = '{"bgeu",      enc_b(13'd12, 5'd2, 5'd1, 3'b111), 32'h8000_0300, 32'h8000_030C, 32'h0, 0, 1, 0};
        vt[27] = '{"ill_br010", enc_b(13'd8, 5'd0, 5'd0, 3'b010), 32'h8000_0300, 32'h8000_0304, 32'h0, 0, 0, 1};
        vt[28] = '{"ill_jalr",  enc_i(12'd0, 5'd1, 3'b001, 5'd1, 7'b1100111), 32'h8000_0300, 32'h8000_0304, 32'h0, 0, 0, 1};
        vt[29] = '{"jal_wrap",  enc_j(21'd8, 5'd0), 32'hFFFF_FFFC, 32'h0000_0004, 32'h0, 0, 1, 0};
        vt[30] = '{"addi_neg",  enc_i(12'hFFF, 5'd1, 3'b000, 5'd9, OPI), 32'h8000_0400, 32'h8000_0404, 32'h8000_0203, 1, 0, 0};
        vt[31] = '{"xori",      enc_i(12'hFFF, 5'd1, 3'b100, 5'd9, OPI), 32'h8000_0404, 32'h8000_0408, 32'h7FFF_FDFB, 1, 0, 0};
        vt[32] = '{"andi",      enc_i(12'h7FF, 5'd1, 3'b111, 5'd9, OPI), 32'h8000_0408, 32'h8000_040C, 32'h0000_0204, 1, 0, 0};
        vt[33] = '{"sltiu",     enc_i(12'hFFF, 5'd2, 3'b011, 5'd9, OPI), 32'h8000_040C, 32'h8000_0410, 32'h1, 1, 0, 0};
        vt[34] = '{"slti",      enc_i(12'hFFF, 5'd2, 3'b010, 5'd9, OPI), 32'h8000_0410, 32'h8000_0414, 32'h0, 1, 0, 0};

        reset = 1'b1;
        valid = 1'b0;
        insn  = 32'h0;
        pc    = 32'h0;
`ifdef RV32I_DBG_READ_EN
        dbg_addr = 5'd0;
`endif
        tick();
        tick();
        check("reset_state", 0, 32'h8000_0000, 32'h0, 0, 0, 0);
        reset = 1'b0;
        tick();
        check("idle_after_reset", 0, 32'h8000_0000, 32'h0, 0, 0, 0);
`ifdef RV32I_DBG_READ_EN
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            #1;
            n_tests++;
            if (dbg_data !== 32'h0) begin
                n_fail++;
                $display("FAIL dbg_reg_zero x%0d: got %h want 0", r, dbg_data);
            end
        end
`endif

        for (int k = 0; k < 35; k++) begin
            valid = 1'b1;
            insn  = vt[k].insn;
            pc    = vt[k].pc;
            tick();
            check(vt[k].name, 1, vt[k].nxt, vt[k].wbd, vt[k].wen, vt[k].br, vt[k].ill);
        end

        // idle cycle: o_valid drops, the rest holds the last result
        valid = 1'b0;
        insn  = enc_i(12'd7, 5'd0, 3'b000, 5'd11, OPI);
        tick();
        check("idle_hold", 0, 32'h8000_0414, 32'h0, 1, 0, 0);
        valid = 1'b1;
        insn  = enc_i(12'd0, 5'd11, 3'b000, 5'd12, OPI);
        pc    = 32'h8000_0500;
        tick();
        check("idle_no_write", 1, 32'h8000_0504, 32'h0, 1, 0, 0);

        // reset with a valid instruction present discards it and clears the regfile
        reset = 1'b1;
        insn  = enc_i(12'd7, 5'd0, 3'b000, 5'd9, OPI);
        pc    = 32'h8000_0600;
        tick();
        check("reset_with_valid", 0, 32'h8000_0000, 32'h0, 0, 0, 0);
        reset = 1'b0;
        insn  = enc_i(12'd0, 5'd9, 3'b000, 5'd10, OPI);
        pc    = 32'h8000_0000;
        tick();
        check("x9_not_written", 1, 32'h8000_0004, 32'h0, 1, 0, 0);
        insn  = enc_i(12'd0, 5'd1, 3'b000, 5'd10, OPI);
        pc    = 32'h8000_0004;
        tick();
        check("x1_cleared", 1, 32'h8000_0008, 32'h0, 1, 0, 0);
`ifdef RV32I_DBG_READ_EN
        insn  = enc_i(12'h123, 5'd0, 3'b000, 5'd13, OPI);
        tick();
        valid    = 1'b0;
        dbg_addr = 5'd13;
        #1;
        n_tests++;
        if (dbg_data !== 32'h0000_0123) begin
            n_fail++;
            $display("FAIL dbg_read_x13: got %h want 00000123", dbg_data);
        end
`endif
        valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
